// File: rtl/cnt_shift_pkg.sv
// Shared encodings and default widths for the counter / shift-register primitives.
package cnt_shift_pkg;

  // Counter direction encodings
  localparam int DIR_UP   = 0;
  localparam int DIR_DOWN = 1;

  // Shift direction encodings
  localparam int SHIFT_TO_MSB = 0;  // serial input enters bit 0
  localparam int SHIFT_TO_LSB = 1;  // serial input enters the MSB

  // Default widths
  localparam int CNT_WIDTH_DEF = 8;
  localparam int SR_WIDTH_DEF  = 8;

endpackage : cnt_shift_pkg

// File: rtl/cnt_shift_prims_if.sv
// Control/data bundle for the counter and shift-register primitive pair.
interface cnt_shift_prims_if #(
  parameter int CNT_WIDTH = 8,
  parameter int SR_WIDTH  = 8
);

  logic                 cnt_en;
  logic                 cnt_sload;
  logic [CNT_WIDTH-1:0] cnt_data;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 cnt_tc;

  logic                 sr_en;
  logic                 sr_load;
  logic [SR_WIDTH-1:0]  sr_data;
  logic                 sr_shiftin;
  logic [SR_WIDTH-1:0]  sr_q;
  logic                 sr_shiftout;

  // User side: drives controls, observes state
  modport master (
    output cnt_en, cnt_sload, cnt_data,
    output sr_en, sr_load, sr_data, sr_shiftin,
    input  cnt_q, cnt_tc,
    input  sr_q, sr_shiftout
  );

  // Primitive side: consumes controls, produces state
  modport slave (
    input  cnt_en, cnt_sload, cnt_data,
    input  sr_en, sr_load, sr_data, sr_shiftin,
    output cnt_q, cnt_tc,
    output sr_q, sr_shiftout
  );

endinterface : cnt_shift_prims_if

// File: rtl/prim_counter.sv
// Loadable up/down binary counter with combinational terminal-count flag.
// Priority: clear > load > count > hold. Wraps modulo 2^WIDTH.
module prim_counter
  import cnt_shift_pkg::*;
#(
  parameter int WIDTH     = CNT_WIDTH_DEF,
  parameter int DIRECTION = DIR_UP
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             en_i,
  input  logic             sload_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("prim_counter: WIDTH must be in 1..32");
  end
  if (DIRECTION != DIR_UP && DIRECTION != DIR_DOWN) begin : g_bad_dir
    $error("prim_counter: DIRECTION must be DIR_UP or DIR_DOWN");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: a load replaces the value outright, it is never also stepped
  always_comb begin
    cnt_d = cnt_q;
    if (sload_i) begin
      cnt_d = data_i;
    end else if (en_i) begin
      if (DIRECTION == DIR_DOWN) begin
        cnt_d = cnt_q - ONE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (sclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o  = cnt_q;
  // Terminal count follows the current value only; nothing is latched on wrap
  assign tc_o = (DIRECTION == DIR_DOWN) ? (cnt_q == '0) : (cnt_q == '1);

endmodule : prim_counter

// File: rtl/prim_shiftreg.sv
// Parallel-load shift register with serial in/out.
// Priority: clear > load > shift > hold.
module prim_shiftreg
  import cnt_shift_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH_DEF,
  parameter int DIRECTION = SHIFT_TO_MSB
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shiftin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             shiftout_o
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("prim_shiftreg: WIDTH must be in 2..64");
  end
  if (DIRECTION != SHIFT_TO_MSB && DIRECTION != SHIFT_TO_LSB) begin : g_bad_dir
    $error("prim_shiftreg: DIRECTION must be SHIFT_TO_MSB or SHIFT_TO_LSB");
  end

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next contents: a load wins over a shift, so held load reloads every cycle
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (en_i) begin
      if (DIRECTION == SHIFT_TO_LSB) begin
        sr_d = {shiftin_i, sr_q[WIDTH-1:1]};
      end else begin
        sr_d = {sr_q[WIDTH-2:0], shiftin_i};
      end
    end
  end

  // Shift register with synchronous clear
  always_ff @(posedge clk) begin
    if (sclr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o        = sr_q;
  // Serial output is the bit that leaves on the next shift
  assign shiftout_o = (DIRECTION == SHIFT_TO_LSB) ? sr_q[0] : sr_q[WIDTH-1];

endmodule : prim_shiftreg

// File: rtl/cnt_shift_prims.sv
// Wrapper pairing an independent counter and shift register on one clock/clear.
module cnt_shift_prims
  import cnt_shift_pkg::*;
#(
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
  parameter int CNT_DIRECTION = DIR_UP,
  parameter int SR_WIDTH      = SR_WIDTH_DEF,
  parameter int SR_DIRECTION  = SHIFT_TO_MSB
) (
  input  logic               clk,
  input  logic               sclr,
  cnt_shift_prims_if.slave   bus
);

  prim_counter #(
    .WIDTH     (CNT_WIDTH),
    .DIRECTION (CNT_DIRECTION)
  ) u_counter (
    .clk     (clk),
    .sclr    (sclr),
    .en_i    (bus.cnt_en),
    .sload_i (bus.cnt_sload),
    .data_i  (bus.cnt_data),
    .q_o     (bus.cnt_q),
    .tc_o    (bus.cnt_tc)
  );

  prim_shiftreg #(
    .WIDTH     (SR_WIDTH),
    .DIRECTION (SR_DIRECTION)
  ) u_shiftreg (
    .clk        (clk),
    .sclr       (sclr),
    .en_i       (bus.sr_en),
    .load_i     (bus.sr_load),
    .data_i     (bus.sr_data),
    .shiftin_i  (bus.sr_shiftin),
    .q_o        (bus.sr_q),
    .shiftout_o (bus.sr_shiftout)
  );

endmodule : cnt_shift_prims

// File: tb/tb_cnt_shift_prims.sv
// Bench for cnt_shift_prims: an up/shift-to-MSB instance and a down/shift-to-LSB
// instance share the same stimulus and are compared every cycle against an
// arithmetic model, with directed literal checks along the way.
module tb_cnt_shift_prims;
  import cnt_shift_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sclr;
  logic       cnt_en, cnt_sload;
  logic [7:0] cnt_data;
  logic       sr_en, sr_load, sr_shiftin;
  logic [7:0] sr_data;

  cnt_shift_prims_if #(.CNT_WIDTH(8), .SR_WIDTH(8)) bus_up ();
  cnt_shift_prims_if #(.CNT_WIDTH(8), .SR_WIDTH(8)) bus_dn ();

  assign bus_up.cnt_en     = cnt_en;
  assign bus_up.cnt_sload  = cnt_sload;
  assign bus_up.cnt_data   = cnt_data;
  assign bus_up.sr_en      = sr_en;
  assign bus_up.sr_load    = sr_load;
  assign bus_up.sr_data    = sr_data;
  assign bus_up.sr_shiftin = sr_shiftin;
  assign bus_dn.cnt_en     = cnt_en;
  assign bus_dn.cnt_sload  = cnt_sload;
  assign bus_dn.cnt_data   = cnt_data;
  assign bus_dn.sr_en      = sr_en;
  assign bus_dn.sr_load    = sr_load;
  assign bus_dn.sr_data    = sr_data;
  assign bus_dn.sr_shiftin = sr_shiftin;

  cnt_shift_prims #(
    .CNT_WIDTH(8), .CNT_DIRECTION(DIR_UP), .SR_WIDTH(8), .SR_DIRECTION(SHIFT_TO_MSB)
  ) u_up (.clk(clk), .sclr(sclr), .bus(bus_up));

  cnt_shift_prims #(
    .CNT_WIDTH(8), .CNT_DIRECTION(DIR_DOWN), .SR_WIDTH(8), .SR_DIRECTION(SHIFT_TO_LSB)
  ) u_dn (.clk(clk), .sclr(sclr), .bus(bus_dn));

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic on 8-bit values
  int m_cnt_up = 0, m_cnt_dn = 0, m_sr_up = 0, m_sr_dn = 0;

  always @(posedge clk) begin
    if (sclr) begin
      m_cnt_up <= 0; m_cnt_dn <= 0; m_sr_up <= 0; m_sr_dn <= 0;
    end else begin
      if (cnt_sload) begin
        m_cnt_up <= int'(cnt_data); m_cnt_dn <= int'(cnt_data);
      end else if (cnt_en) begin
        m_cnt_up <= (m_cnt_up + 1) % 256;
        m_cnt_dn <= (m_cnt_dn + 255) % 256;
      end
      if (sr_load) begin
        m_sr_up <= int'(sr_data); m_sr_dn <= int'(sr_data);
      end else if (sr_en) begin
        m_sr_up <= (m_sr_up * 2 + int'(sr_shiftin)) % 256;
        m_sr_dn <= m_sr_dn / 2 + int'(sr_shiftin) * 128;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (check_en) begin
      check("up.cnt_q", bus_up.cnt_q, m_cnt_up);
      check("up.cnt_tc", bus_up.cnt_tc, (m_cnt_up == 255) ? 1 : 0);
      check("up.sr_q", bus_up.sr_q, m_sr_up);
      check("up.sr_shiftout", bus_up.sr_shiftout, (m_sr_up >= 128) ? 1 : 0);
      check("dn.cnt_q", bus_dn.cnt_q, m_cnt_dn);
      check("dn.cnt_tc", bus_dn.cnt_tc, (m_cnt_dn == 0) ? 1 : 0);
      check("dn.sr_q", bus_dn.sr_q, m_sr_dn);
      check("dn.sr_shiftout", bus_dn.sr_shiftout, m_sr_dn % 2);
    end
  end

  // One clock edge; inputs are changed and outputs read 2 time units after it
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    sclr = 1'b1; cnt_en = 1'b0; cnt_sload = 1'b0; cnt_data = 8'h00;
    sr_en = 1'b0; sr_load = 1'b0; sr_data = 8'h00; sr_shiftin = 1'b0;

    // Reset
    step(); step();
    check_en = 1'b1;
    check("rst up.cnt_q", bus_up.cnt_q, 0);
    check("rst up.cnt_tc", bus_up.cnt_tc, 0);
    check("rst dn.cnt_tc", bus_dn.cnt_tc, 1);
    check("rst up.sr_q", bus_up.sr_q, 0);
    check("rst sr_shiftout", bus_up.sr_shiftout | bus_dn.sr_shiftout, 0);

    // Count from reset
    sclr = 1'b0; cnt_en = 1'b1;
    step();
    check("count first", bus_up.cnt_q, 1);
    repeat (9) step();
    check("count 10", bus_up.cnt_q, 10);
    check("count dn 10", bus_dn.cnt_q, 246);

    // Clear pulse mid-count
    sclr = 1'b1; step();
    check("mid sclr", bus_up.cnt_q, 0);
    sclr = 1'b0; step();
    check("resume 1", bus_up.cnt_q, 1);
    step();
    check("resume 2", bus_up.cnt_q, 2);

    // Enable hold at 7
    repeat (5) step();
    check("reach 7", bus_up.cnt_q, 7);
    cnt_en = 1'b0; step(); step();
    check("hold 7", bus_up.cnt_q, 7);
    cnt_en = 1'b1; step();
    check("reenable 8", bus_up.cnt_q, 8);

    // Load 250 and wrap up
    cnt_sload = 1'b1; cnt_data = 8'd250; step();
    check("load 250", bus_up.cnt_q, 250);
    cnt_sload = 1'b0;
    for (int k = 251; k <= 255; k++) begin
      step();
      check("up seq", bus_up.cnt_q, k);
    end
    check("tc at 255", bus_up.cnt_tc, 1);
    step();
    check("wrap 0", bus_up.cnt_q, 0);
    check("tc after wrap", bus_up.cnt_tc, 0);
    step();
    check("wrap 1", bus_up.cnt_q, 1);

    // Down wrap
    cnt_sload = 1'b1; cnt_data = 8'd1; step();
    check("dn load 1", bus_dn.cnt_q, 1);
    cnt_sload = 1'b0; step();
    check("dn 0", bus_dn.cnt_q, 0);
    check("dn tc", bus_dn.cnt_tc, 1);
    step();
    check("dn wrap 255", bus_dn.cnt_q, 255);
    check("dn tc clear", bus_dn.cnt_tc, 0);
    cnt_en = 1'b0;

    // Serial fill with ones
    sclr = 1'b1; step();
    sclr = 1'b0; sr_en = 1'b1; sr_shiftin = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("fill up", bus_up.sr_q, (64'd1 << k) - 64'd1);
      check("fill dn", bus_dn.sr_q, (64'hFF << (8 - k)) & 64'hFF);
      check("fill shiftout", bus_up.sr_shiftout, (k == 8) ? 1 : 0);
    end

    // Load priority over shift
    sr_load = 1'b1; sr_data = 8'hA5; step();
    check("load A5 up", bus_up.sr_q, 8'hA5);
    check("load A5 dn", bus_dn.sr_q, 8'hA5);
    sr_load = 1'b0; sr_shiftin = 1'b0; step();
    check("shift up 4A", bus_up.sr_q, 8'h4A);
    check("shift dn 52", bus_dn.sr_q, 8'h52);
    sr_load = 1'b1; sr_en = 1'b0; sr_data = 8'h00; step();
    check("load 00", bus_up.sr_q, 0);

    // Load held with enable: reloads, no shift
    sr_data = 8'h3C; sr_en = 1'b1; sr_shiftin = 1'b1; step(); step();
    check("held load", bus_up.sr_q, 8'h3C);

    // Clear beats loads
    sclr = 1'b1; cnt_sload = 1'b1; cnt_data = 8'h55; sr_load = 1'b1; sr_data = 8'hFF;
    step();
    check("sclr+load cnt", bus_up.cnt_q, 0);
    check("sclr+load sr", bus_up.sr_q | bus_dn.sr_q, 0);
    check("sclr+load dn tc", bus_dn.cnt_tc, 1);
    sclr = 1'b0; cnt_sload = 1'b0; sr_load = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sclr       = ($urandom_range(0, 40) == 0);
      cnt_en     = ($urandom_range(0, 3) != 0);
      cnt_sload  = ($urandom_range(0, 9) == 0);
      cnt_data   = 8'($urandom);
      sr_en      = ($urandom_range(0, 3) != 0);
      sr_load    = ($urandom_range(0, 9) == 0);
      sr_data    = 8'($urandom);
      sr_shiftin = 1'($urandom);
      step();
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cnt_shift_prims

// File: doc/cnt_shift_prims.md
Name: cnt_shift_prims

Overview:
- Library primitive pair: a loadable up/down binary counter and a parallel-load shift register, sharing one clock and one reset.
- Used as generic building blocks (timers, serializers) across the design.
- The two datapaths are fully independent except for `clk`/`sclr`.

Parameters:
- CNT_WIDTH, 8, counter width in bits (1..32).
- CNT_DIRECTION, 0, 0 = count up, 1 = count down.
- SR_WIDTH, 8, shift register width in bits (2..64).
- SR_DIRECTION, 0, 0 = shift toward MSB (`sr_shiftin` enters bit 0), 1 = shift toward LSB (`sr_shiftin` enters MSB).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- sclr  in  1  reset, synchronous, active-high; clears both counter and shift register.
- cnt_en  in  1  count enable.
- cnt_sload  in  1  synchronous load of `cnt_data`.
- cnt_data  in  CNT_WIDTH  load value.
- cnt_q  out  CNT_WIDTH  registered count.
- cnt_tc  out  1  terminal count, combinational.
  - CNT_DIRECTION=0: `cnt_q` == all ones.
  - CNT_DIRECTION=1: `cnt_q` == 0.
- sr_en  in  1  shift enable.
- sr_load  in  1  synchronous parallel load of `sr_data`.
- sr_data  in  SR_WIDTH  parallel load value.
- sr_shiftin  in  1  serial input bit.
- sr_q  out  SR_WIDTH  registered register contents.
- sr_shiftout  out  1  combinational serial output.
  - SR_DIRECTION=0: `sr_q[SR_WIDTH-1]`.
  - SR_DIRECTION=1: `sr_q[0]`.

Behaviour:
- Reset values: `cnt_q`=0, `sr_q`=0. Hence `sr_shiftout`=0, and `cnt_tc`=0 (up) / 1 (down).
- No asynchronous behaviour; `sclr` is sampled only at the `clk` edge.
- Counter priority per edge:
  1. `sclr` → `cnt_q` ← 0.
  2. else `cnt_sload` → `cnt_q` ← `cnt_data` (independent of `cnt_en`).
  3. else `cnt_en` → `cnt_q` ← `cnt_q` ±1, modulo 2^CNT_WIDTH.
  4. else hold.
- Counter wrap-around:
  - Up: all ones → 0.
  - Down: 0 → all ones.
  - No sticky flag; `cnt_tc` reflects the current value only.
- Shift register priority per edge:
  1. `sclr` → `sr_q` ← 0.
  2. else `sr_load` → `sr_q` ← `sr_data` (independent of `sr_en`).
  3. else `sr_en` → shift by one.
  4. else hold.
- Shift detail:
  - SR_DIRECTION=0: `sr_q` ← {`sr_q[SR_WIDTH-2:0]`, `sr_shiftin`}.
  - SR_DIRECTION=1: `sr_q` ← {`sr_shiftin`, `sr_q[SR_WIDTH-1:1]`}.
- Latency: every effect is visible on the outputs the cycle after the edge that samples the control.
- Simultaneous events:
  - `sclr` overrides load/enable in the same cycle.
  - Load overrides count/shift; a loaded value is not also incremented/shifted in that cycle.
- Held `sr_load`: reloads every cycle, with `sr_en` irrelevant.
- Held `cnt_sload`: reloads every cycle.
- Reset mid-operation: takes effect at the next edge; the operation resumes from 0 on the first edge after `sclr` deasserts.
- No X propagation from unused inputs; parameters are checked at elaboration (illegal width → `$error`).

Decomposition:
- Package cnt_shift_pkg:
  - Direction encodings as localparams: DIR_UP/DIR_DOWN, SHIFT_TO_MSB/SHIFT_TO_LSB.
  - Default widths.
- Sub-modules: the natural split is two leaves, prim_counter and prim_shiftreg, instantiated by cnt_shift_prims.
  - Each leaf owns its own clk/sclr-based register.
  - No logic in the wrapper beyond wiring.

Test Plan:
- Reset/count: `sclr`=1 for 2 cycles, then `cnt_en`=1 → `cnt_q` 0,1,2,…; 10 enabled edges → `cnt_q`=10; `sclr` pulse mid-count → `cnt_q`=0 next cycle, then 1,2….
- Enable hold: `cnt_en`=0 for 2 cycles at `cnt_q`=7 → stays 7; re-enable → 8.
- Load and wrap: `cnt_sload`=1 with `cnt_data`=250 for one cycle, `cnt_en`=1 → sequence and flags:
  - 250,251,…,255 (`cnt_tc`=1 at 255), then 0, 1.
  - Down build: load 1 → 1, 0 (`cnt_tc`=1), 255.
- Shift serial fill: after reset, `sr_en`=1, `sr_shiftin`=1, SR_DIRECTION=0 → `sr_q` 0x01,0x03,0x07,…,0xFF; `sr_shiftout` first 1 after the 8th edge.
- Parallel load/priority: `sr_load`=1, `sr_data`=0xA5, `sr_en`=1 → `sr_q`=0xA5 (no shift); next edge with `sr_load`=0, `sr_shiftin`=0 → 0x4A; `sr_load`=1 with `sr_en`=0, `sr_data`=0x00 → 0x00.
- Simultaneous `sclr`+load: `sclr`=1, `cnt_sload`=1 (`cnt_data`=0x55), `sr_load`=1 (`sr_data`=0xFF) → `cnt_q`=0, `sr_q`=0.
